fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, FIFO word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, FIFO address width; pass-through only, no logic.
REQ-003 SHALL have port rclk  input  1  read-domain clock; single clock, all state on its rising edge.
REQ-004 SHALL have port rrst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rempty  input  1  registered empty flag from the read-pointer/empty stage.
REQ-006 SHALL have port rdata  input  DATASIZE  FIFO memory read data at the current read address; combinational, valid when rempty=0.
REQ-007 SHALL have port rinc  output  1  read-increment request to the read-pointer/empty stage.
REQ-008 SHALL have port flush  input  1  synchronous clear of the internal buffer; FIFO pointers unaffected.
REQ-009 SHALL have port m_valid  output  1  downstream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  DATASIZE  downstream data, registered.
REQ-012 SHALL have port occ  output  2  buffer occupancy, 0..2.

Function
REQ-013 SHALL implement a 2-entry first-word-fall-through output buffer: head register (drives m_data) and skid register.
REQ-014 SHALL use a state machine with states EMPTY (occ=0), ONE (occ=1), TWO (occ=2); occ is the state encoding.
REQ-015 SHALL drive rinc = ~rempty & (state != TWO); no combinational path from m_ready to rinc.
REQ-016 SHALL capture rdata on the rclk edge where rinc=1 (push); pop occurs when m_valid & m_ready.
REQ-017 SHALL drive m_valid = (state != EMPTY), directly from state.
REQ-018 Transitions: EMPTY+push -> ONE, data to head; ONE+push+pop -> ONE, data to head; ONE+push only -> TWO, data to skid; ONE+pop only -> EMPTY; TWO+pop -> ONE, skid moves to head; push impossible in TWO.
REQ-019 SHALL give first-word latency of 1 cycle: rempty falling at edge N -> m_valid=1 after edge N+1.
REQ-020 SHALL sustain 1 word/cycle when m_ready is held 1 and rempty stays 0.
REQ-021 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-022 SHALL give flush priority over push/pop: next state EMPTY, buffered words discarded; a push in the same cycle is also discarded.
REQ-023 SHALL never push when rempty=1, i.e. no underflow; never lose or duplicate a word in order.

Reset
REQ-024 SHALL on rrst_n=0 asynchronously force state EMPTY, occ=0, m_valid=0, m_data=0, skid=0.
REQ-025 SHALL hold rinc=0 while in reset, independent of rempty.
REQ-026 SHALL discard buffered data on reset mid-stream; first post-reset word is the FIFO head at that time.

Structure
REQ-027 SHALL take the state enum (EMPTY/ONE/TWO) and DATASIZE/ADDRSIZE defaults from the shared package fifo_pkg.
REQ-028 SHALL be a single module with no sub-modules; instantiated beside rptr_empty and fifomem in the FIFO top.
REQ-029 SHALL stay within 120-400 lines of RTL.

Verification
REQ-030 Reset scenario: rrst_n=0 with rempty=0 -> rinc=0, m_valid=0, m_data=0, occ=0.
REQ-031 Single-word scenario: rempty 1->0 with rdata=8'hA5, m_ready=1 -> m_valid=1, m_data=A5 one cycle after push; occ returns to 0.
REQ-032 Backpressure scenario: 4 words 01..04, m_ready=0 -> occ=2, rinc=0, m_data=01; release m_ready -> 01,02,03,04 delivered in order.
REQ-033 Streaming scenario: 16 words, m_ready=1 -> one word per cycle after a 1-cycle fill latency, no bubbles.
REQ-034 Flush scenario: occ=2, flush=1 with rempty=0 -> occ=0 next cycle, m_valid=0; next push is the following FIFO word.
REQ-035 Random scenario: random rempty/m_ready, 1000 words -> scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO read-side blocks.
//   - DATASIZE_DEF / ADDRSIZE_DEF : default word width and address width
//   - rd_state_e                  : output-buffer state; the encoding equals
//                                   the number of buffered words (0..2)
//   - occ_of                      : maps a buffer state to its occupancy
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATASIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 4;

    // Encoding is the occupancy itself, so occ can be taken straight from state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_state_e;

    function automatic logic [1:0] occ_of(input rd_state_e s);
        logic [1:0] occ_v;
        occ_v = s;
        return occ_v;
    endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Converts the read side of an asynchronous FIFO (empty flag + combinational
//   read data + increment strobe) into a valid/ready stream with a registered
//   data output. A 2-entry first-word-fall-through buffer (head + skid) lets
//   rinc be decided from buffer state only, so m_ready never reaches rinc
//   combinationally while still sustaining one word per cycle.
//
//   Parameters
//     DATASIZE : word width in bits
//     ADDRSIZE : FIFO address width, carried for the enclosing FIFO only
//
//   Ports
//     rclk    in   read-domain clock
//     rrst_n  in   asynchronous active-low reset
//     rempty  in   registered empty flag from the read-pointer stage
//     rdata   in   FIFO memory data at the current read address
//     rinc    out  read-increment request (a word is consumed when high)
//     flush   in   synchronous clear of the buffer, FIFO pointers untouched
//     m_valid out  downstream data valid
//     m_ready in   downstream accept
//     m_data  out  downstream data (head register)
//     occ     out  number of buffered words, 0..2
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic [1:0]          occ
);

    // ADDRSIZE matters only to the neighbouring pointer/memory blocks; any
    // legal value folds this term to a constant 1.
    localparam logic ADDR_OK = (ADDRSIZE > 0) ? 1'b1 : 1'b0;

    rd_state_e           state_r;
    logic [DATASIZE-1:0] head_r;
    logic [DATASIZE-1:0] skid_r;

    logic                push_s;
    logic                pop_s;

    // Read request depends only on the empty flag and registered state; the
    // reset term keeps the FIFO pointer still while rrst_n is low.
    assign rinc    = rrst_n & ~rempty & (state_r != TWO) & ADDR_OK;
    assign push_s  = rinc;
    assign m_valid = (state_r != EMPTY);
    assign pop_s   = m_valid & m_ready;
    assign m_data  = head_r;
    assign occ     = occ_of(state_r);

    // Buffer FSM: head always holds the oldest word, skid the younger one.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= EMPTY;
            head_r  <= {DATASIZE{1'b0}};
            skid_r  <= {DATASIZE{1'b0}};
        end else if (flush) begin
            // Buffered words and any word read this cycle are dropped.
            state_r <= EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        head_r  <= rdata;
                        state_r <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        // Head leaves and the new word replaces it directly.
                        head_r  <= rdata;
                        state_r <= ONE;
                    end else if (push_s) begin
                        skid_r  <= rdata;
                        state_r <= TWO;
                    end else if (pop_s) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    // rinc is low here, so only a pop can happen.
                    if (pop_s) begin
                        head_r  <= skid_r;
                        state_r <= ONE;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] occ;

    int n_vec = 0;
    int n_err = 0;

    // FIFO emulation: words loaded by the stimulus, read pointer moved by rinc.
    logic [7:0] src_mem [0:2047];
    int         src_wr  = 0;
    int         src_ptr = 0;
    bit         stall   = 1'b1;

    // Reference model: the buffered words in order, and the delivered log.
    logic [7:0] mq[$];
    logic [7:0] dlv_q[$];

    always #5 rclk = ~rclk;

    assign rempty = stall || (src_ptr >= src_wr);
    assign rdata  = src_mem[src_ptr[10:0]];

    fifo_rd_stream #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        src_mem[src_wr[10:0]] = w;
        src_wr++;
    endtask

    // FIFO read pointer advances when the DUT consumes a word.
    always @(posedge rclk) begin
        if (rrst_n && rinc) src_ptr <= src_ptr + 1;
    end

    // Delivered-word log for scoreboarding.
    always @(posedge rclk) begin
        if (rrst_n && m_valid && m_ready) dlv_q.push_back(m_data);
    end

    // Model: a word is taken whenever the FIFO is non-empty and fewer than two
    // are held; the front leaves on accept; flush or reset empties everything.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mq.delete();
        end else begin
            bit do_push;
            bit do_pop;
            logic [7:0] w;
            do_push = !rempty && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && m_ready;
            w = rdata;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(w);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge rclk) begin
        if (!rrst_n) begin
            chk("cyc_rst_rinc", {31'd0, rinc}, 32'd0);
            chk("cyc_rst_valid", {31'd0, m_valid}, 32'd0);
            chk("cyc_rst_occ", {30'd0, occ}, 32'd0);
        end else begin
            chk("cyc_rinc", {31'd0, rinc}, {31'd0, (!rempty && (mq.size() < 2))});
            chk("cyc_valid", {31'd0, m_valid}, {31'd0, (mq.size() != 0)});
            chk("cyc_occ", {30'd0, occ}, mq.size());
            if (mq.size() != 0) chk("cyc_data", {24'd0, m_data}, {24'd0, mq[0]});
        end
    end

    initial begin
        logic [7:0] bp_exp [4];
        logic       vb [20];
        int base, cnt, first, last, base_src, nbad;
        bit done;

        for (int i = 0; i < 2048; i++) src_mem[i] = 8'h00;
        bp_exp = '{8'h01, 8'h02, 8'h03, 8'h04};

        // Reset with a word waiting in the FIFO.
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        load(8'hA5);
        stall   = 1'b0;
        tick(2);
        chk("rst_rinc", {31'd0, rinc}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_occ", {30'd0, occ}, 32'd0);

        // Single word: rempty falls, A5 appears one cycle after the push.
        stall  = 1'b1;
        rrst_n = 1'b1;
        tick(2);
        stall = 1'b0;
        #1;
        chk("sw_rinc", {31'd0, rinc}, 32'd1);
        tick(1);
        chk("sw_valid", {31'd0, m_valid}, 32'd1);
        chk("sw_data", {24'd0, m_data}, 32'hA5);
        tick(1);
        chk("sw_occ0", {30'd0, occ}, 32'd0);

        // Backpressure: four words, downstream stalled.
        m_ready = 1'b0;
        stall   = 1'b1;
        for (int i = 0; i < 4; i++) load(bp_exp[i]);
        stall = 1'b0;
        tick(5);
        chk("bp_occ", {30'd0, occ}, 32'd2);
        chk("bp_rinc", {31'd0, rinc}, 32'd0);
        chk("bp_data", {24'd0, m_data}, 32'h01);
        base = dlv_q.size();
        m_ready = 1'b1;
        tick(6);
        chk("bp_count", dlv_q.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < dlv_q.size()) chk("bp_order", {24'd0, dlv_q[base+i]}, {24'd0, bp_exp[i]});
            else chk("bp_order_missing", 32'd0, 32'd1);
        end

        // Streaming: 16 words, no bubbles after the 1-cycle fill.
        stall = 1'b1;
        for (int i = 0; i < 16; i++) load(8'h10 + i[7:0]);
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            vb[i] = m_valid;
        end
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (vb[i]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("st_count", cnt, 32'd16);
        chk("st_first", first, 32'd0);
        chk("st_last", last, 32'd15);
        chk("st_lastword", {24'd0, dlv_q[$]}, 32'h1F);

        // Flush while full: buffered 31/32 discarded, next word is 33.
        m_ready = 1'b0;
        stall   = 1'b1;
        for (int i = 0; i < 5; i++) load(8'h31 + i[7:0]);
        stall = 1'b0;
        tick(4);
        chk("fl_occ2", {30'd0, occ}, 32'd2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("fl_occ0", {30'd0, occ}, 32'd0);
        chk("fl_valid0", {31'd0, m_valid}, 32'd0);
        tick(1);
        chk("fl_valid1", {31'd0, m_valid}, 32'd1);
        chk("fl_next", {24'd0, m_data}, 32'h33);
        m_ready = 1'b1;
        tick(6);

        // Reset mid-stream: 41/42 discarded, first word after reset is 43.
        m_ready = 1'b0;
        stall   = 1'b1;
        for (int i = 0; i < 4; i++) load(8'h41 + i[7:0]);
        stall = 1'b0;
        tick(4);
        rrst_n = 1'b0;
        tick(2);
        chk("mr_occ0", {30'd0, occ}, 32'd0);
        rrst_n = 1'b1;
        tick(2);
        chk("mr_head", {24'd0, m_data}, 32'h43);
        m_ready = 1'b1;
        tick(4);

        // Random: 1000 words, random empty gaps and backpressure.
        stall    = 1'b1;
        base_src = src_wr;
        for (int i = 0; i < 1000; i++) load($urandom_range(0, 255));
        base = dlv_q.size();
        done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (src_ptr == src_wr && mq.size() == 0) begin
                done = 1'b1;
                break;
            end
            stall   = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        stall   = 1'b1;
        m_ready = 1'b1;
        tick(3);
        chk("rnd_done", {31'd0, done}, 32'd1);
        chk("rnd_count", dlv_q.size() - base, 32'd1000);
        nbad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (base + i >= dlv_q.size() || dlv_q[base+i] !== src_mem[base_src+i]) nbad++;
        end
        chk("rnd_order", nbad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
